// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle shared by the frame-generation master and its RAM responder.
interface wshb_if;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output adr, dat_ms, sel, we, cyc, stb, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  adr, dat_ms, sel, we, cyc, stb, cti, bte,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/wshb_ram_slave.sv
// Wishbone B4 RAM responder: classic cycles plus linear incrementing bursts, programmable wait states.
// Optional WSHB_RAM_ERR_EN: out-of-range high address bits answer with err instead of aliasing.
module wshb_ram_slave #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] INIT_VAL    = 32'h0000_0000
) (
    input logic   sys_clk,
    input logic   sys_rst,
    wshb_if.slave wshb_ifs
);
    localparam int          DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
    localparam logic [2:0]  CTI_INCR  = 3'b010;
    localparam logic [2:0]  CTI_END   = 3'b111;
    localparam logic [1:0]  SRC_ZERO  = 2'd0;
    localparam logic [1:0]  SRC_RAM   = 2'd1;
    localparam logic [1:0]  SRC_BAD   = 2'd2;
    localparam logic [31:0] BAD_WORD  = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        wait_cnt_reg, wait_cnt_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;
    logic              bad_reg, bad_next;
    logic [1:0]        src_reg, src_next;
    logic              we_reg;
    logic [31:0]       wdat_reg;
    logic [3:0]        sel_reg;
    logic [2:0]        cti_reg;

    logic              req, addr_bad, latch_req, enter_ack, step;
    logic [ADDR_W-1:0] req_idx, cur_idx;
    logic              cur_we, cur_bad;
    logic              wr_en, rd_en;
    logic [ADDR_W-1:0] wr_idx, rd_idx;
    logic [31:0]       wr_dat, ram_word;
    logic [3:0]        wr_sel;
    logic              ack, err;
    logic              unused_bits;

    assign req     = wshb_ifs.cyc & wshb_ifs.stb;
    assign req_idx = wshb_ifs.adr[ADDR_W+1:2];

`ifdef WSHB_RAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
    assign addr_bad = |wshb_ifs.adr[31:ADDR_W+2];
`else
    localparam bit ERR_EN = 1'b0;
    assign addr_bad = 1'b0;
`endif

    // byte offset, burst type and the preload value have no effect on the datapath
    assign unused_bits = ^{wshb_ifs.adr, wshb_ifs.bte, INIT_VAL};

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        idx_next      = idx_reg;
        bad_next      = bad_reg;
        src_next      = src_reg;
        latch_req     = 1'b0;
        enter_ack     = 1'b0;
        step          = 1'b0;
        cur_idx       = idx_reg;
        cur_we        = we_reg;
        cur_bad       = bad_reg;
        wr_en         = 1'b0;
        wr_idx        = idx_reg;
        wr_dat        = wshb_ifs.dat_ms;
        wr_sel        = wshb_ifs.sel;
        rd_en         = 1'b0;
        rd_idx        = idx_reg;
        ack           = 1'b0;
        err           = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (req) begin
                    latch_req = 1'b1;
                    idx_next  = req_idx;
                    bad_next  = addr_bad;
                    if (WAIT_STATES == 0) begin
                        state_next = ACK;
                        enter_ack  = 1'b1;
                    end else begin
                        state_next    = WAIT;
                        wait_cnt_next = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (wait_cnt_reg == 4'd0) begin
                    state_next = ACK;
                    enter_ack  = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            ACK: begin
                ack        = ~bad_reg;
                err        = bad_reg;
                state_next = IDLE;
                if (cti_reg == CTI_INCR && req && !bad_reg) begin
                    state_next = BURST;
                    step       = 1'b1;
                end
            end
            BURST: begin
                // ack is qualified by the live strobe so an aborting master never sees a stray beat
                ack        = req & ~bad_reg;
                err        = req & bad_reg;
                state_next = IDLE;
                if (req && !bad_reg) begin
                    wr_en = we_reg;
                    if (wshb_ifs.cti != CTI_END) begin
                        state_next = BURST;
                        step       = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // first beat: straight from the bus when accepted in IDLE, else from the latched request
        if (enter_ack) begin
            if (state_reg == IDLE) begin
                cur_idx = req_idx;
                cur_we  = wshb_ifs.we;
                cur_bad = addr_bad;
            end else begin
                wr_dat = wdat_reg;
                wr_sel = sel_reg;
            end
            wr_idx = cur_idx;
            rd_idx = cur_idx;
            if (cur_bad) begin
                src_next = SRC_BAD;
            end else if (cur_we) begin
                wr_en = 1'b1;
            end else begin
                rd_en    = 1'b1;
                src_next = SRC_RAM;
            end
        end

        // advance to the next burst word and prefetch it so data is ready with its ack
        if (step) begin
            idx_next = idx_reg + ADDR_W'(1);
            bad_next = ERR_EN && (&idx_reg);
            if (!we_reg) begin
                rd_idx = idx_next;
                if (bad_next) begin
                    src_next = SRC_BAD;
                end else begin
                    rd_en    = 1'b1;
                    src_next = SRC_RAM;
                end
            end
        end

        if (sys_rst) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 4'd0;
            idx_reg      <= '0;
            bad_reg      <= 1'b0;
            src_reg      <= SRC_ZERO;
            we_reg       <= 1'b0;
            wdat_reg     <= 32'h0;
            sel_reg      <= 4'h0;
            cti_reg      <= 3'b000;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            idx_reg      <= idx_next;
            bad_reg      <= bad_next;
            src_reg      <= src_next;
            if (latch_req) begin
                we_reg   <= wshb_ifs.we;
                wdat_reg <= wshb_ifs.dat_ms;
                sel_reg  <= wshb_ifs.sel;
                cti_reg  <= wshb_ifs.cti;
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge sys_clk) begin
            if (wr_en && wr_sel[gi]) begin
                mem[wr_idx] <= wr_dat[gi*8 +: 8];
            end
            if (rd_en) begin
                rd_q <= mem[rd_idx];
            end
        end

        assign ram_word[gi*8 +: 8] = rd_q;
    end

    assign wshb_ifs.dat_sm = (src_reg == SRC_RAM) ? ram_word :
                             (src_reg == SRC_BAD) ? BAD_WORD : 32'h0;
    assign wshb_ifs.ack    = ack;
    assign wshb_ifs.err    = err;
    assign wshb_ifs.rty    = 1'b0;
endmodule

// File: tb/tb_wshb_ram_slave.sv
// Scoreboard bench for wshb_ram_slave: three instances (0, 2 and 3 wait states) driven by directed cycles.
module tb_wshb_ram_slave;
    localparam int N = 3;

    typedef struct {
        int          k;
        bit          err;
        bit          chk;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst   [N];
    logic [31:0] m_adr [N];
    logic [31:0] m_dat [N];
    logic [3:0]  m_sel [N];
    logic        m_we  [N];
    logic        m_cyc [N];
    logic        m_stb [N];
    logic [2:0]  m_cti [N];
    logic [1:0]  m_bte [N];
    logic        s_ack [N];
    logic        s_err [N];
    logic        s_rty [N];
    logic [31:0] s_dat [N];

    int   cyc_cnt = 0;
    int   n_cmp   = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    genvar gi;
    for (gi = 0; gi < N; gi++) begin : g_dut
        wshb_if bus ();
        assign bus.adr    = m_adr[gi];
        assign bus.dat_ms = m_dat[gi];
        assign bus.sel    = m_sel[gi];
        assign bus.we     = m_we[gi];
        assign bus.cyc    = m_cyc[gi];
        assign bus.stb    = m_stb[gi];
        assign bus.cti    = m_cti[gi];
        assign bus.bte    = m_bte[gi];
        assign s_ack[gi]  = bus.ack;
        assign s_err[gi]  = bus.err;
        assign s_rty[gi]  = bus.rty;
        assign s_dat[gi]  = bus.dat_sm;

        wshb_ram_slave #(
            .ADDR_W      (10),
            .WAIT_STATES ((gi == 0) ? 0 : (gi == 1) ? 2 : 3),
            .INIT_VAL    (32'h0000_0000)
        ) u_dut (
            .sys_clk  (clk),
            .sys_rst  (rst[gi]),
            .wshb_ifs (bus)
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 3;
    endfunction

    function automatic void push(input int k, input bit err, input bit chk, input logic [31:0] dat, input int cyc);
        exp_t e;
        e.k = k; e.err = err; e.chk = chk; e.dat = dat; e.cyc = cyc;
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every response pops the oldest expectation and checks instance, kind, cycle and data.
    always @(negedge clk) begin : mon
        exp_t e;
        for (int k = 0; k < N; k++) begin
            if (s_ack[k] || s_err[k]) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stray_resp dut%0d: ack=%0b err=%0b dat=%h cycle=%0d, required no response",
                             k, s_ack[k], s_err[k], s_dat[k], cyc_cnt);
                end else begin
                    e = exp_q.pop_front();
                    if (e.k != k || s_ack[k] != !e.err || s_err[k] != e.err || s_rty[k] != 1'b0 ||
                        e.cyc != cyc_cnt || (e.chk && s_dat[k] !== e.dat)) begin
                        n_fail++;
                        $display("FAIL resp dut%0d: ack=%0b err=%0b dat=%h cycle=%0d, required dut%0d ack=%0b err=%0b dat=%h cycle=%0d",
                                 k, s_ack[k], s_err[k], s_dat[k], cyc_cnt, e.k, !e.err, e.err, e.dat, e.cyc);
                    end else begin
                        $display("resp dut%0d ack=%0b err=%0b dat=%h cycle=%0d ok", k, s_ack[k], s_err[k], s_dat[k], cyc_cnt);
                    end
                end
            end
        end
    end

    task automatic wait_resp(input int k);
        int t;
        t = 0;
        while (!(s_ack[k] || s_err[k]) && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        n_cmp++;
        if (t >= 40) begin
            n_fail++;
            $display("FAIL resp_timeout dut%0d: no ack/err within %0d cycles, required a response", k, t);
        end
    endtask

    task automatic classic(input int k, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input bit exp_err, input logic [31:0] exp_dat);
        @(posedge clk); #1;
        m_adr[k] = adr; m_dat[k] = dat; m_sel[k] = sel; m_we[k] = we;
        m_cti[k] = 3'b000; m_cyc[k] = 1'b1; m_stb[k] = 1'b1;
        push(k, exp_err, !we || exp_err, exp_dat, cyc_cnt + 1 + ws_of(k));
        wait_resp(k);
        @(posedge clk); #1;
        m_cyc[k] = 1'b0; m_stb[k] = 1'b0; m_we[k] = 1'b0;
    endtask

    task automatic burst_rd(input int k, input logic [31:0] adr, input int nb, input bit drop,
                            input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
        logic [31:0] ed [4];
        ed = '{d0, d1, d2, d3};
        @(posedge clk); #1;
        m_adr[k] = adr; m_we[k] = 1'b0; m_sel[k] = 4'hF;
        m_cti[k] = (nb == 1 && !drop) ? 3'b111 : 3'b010;
        m_cyc[k] = 1'b1; m_stb[k] = 1'b1;
        for (int i = 0; i < nb; i++) push(k, 1'b0, 1'b1, ed[i], cyc_cnt + 1 + ws_of(k) + i);
        for (int i = 0; i < nb; i++) begin
            wait_resp(k);
            @(posedge clk); #1;
            if (i + 1 < nb) begin
                m_adr[k] = m_adr[k] + 32'd4;
                m_cti[k] = (i + 2 == nb && !drop) ? 3'b111 : 3'b010;
            end
        end
        if (drop) begin
            m_stb[k] = 1'b0;
            @(negedge clk);
            chk("burst_abort_ack", {31'h0, s_ack[k]}, 32'h0);
            @(posedge clk); #1;
        end
        m_cyc[k] = 1'b0; m_stb[k] = 1'b0; m_cti[k] = 3'b000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1; m_adr[k] = '0; m_dat[k] = '0; m_sel[k] = '0; m_we[k] = 1'b0;
            m_cyc[k] = 1'b0; m_stb[k] = 1'b0; m_cti[k] = '0; m_bte[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("reset_ack%0d", k), {31'h0, s_ack[k]}, 32'h0);
            chk($sformatf("reset_err%0d", k), {31'h0, s_err[k]}, 32'h0);
            chk($sformatf("reset_rty%0d", k), {31'h0, s_rty[k]}, 32'h0);
            chk($sformatf("reset_dat%0d", k), s_dat[k], 32'h0);
        end

        // two wait states: latency and byte lanes
        classic(1, 1'b1, 32'h10, 32'hBABECAFE, 4'hF, 1'b0, 32'h0);
        classic(1, 1'b0, 32'h10, 32'h0,       4'hF, 1'b0, 32'hBABECAFE);
        classic(1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0);
        classic(1, 1'b1, 32'h20, 32'h12345678, 4'b0101, 1'b0, 32'h0);
        classic(1, 1'b0, 32'h20, 32'h0,        4'hF, 1'b0, 32'hFF34FF78);

        // zero wait states: fill, bursts, aborted burst
        for (int i = 0; i < 4; i++) classic(0, 1'b1, 32'h40 + 32'(4 * i), 32'(i + 1), 4'hF, 1'b0, 32'h0);
        burst_rd(0, 32'h40, 4, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4);
        burst_rd(0, 32'h44, 3, 1'b0, 32'd2, 32'd3, 32'd4, 32'd0);
        burst_rd(0, 32'h40, 2, 1'b1, 32'd1, 32'd2, 32'd0, 32'd0);
        classic(0, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 32'd1);

        // high address bits: error response or aliasing onto word 0
        classic(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b0, 32'h0);
`ifdef WSHB_RAM_ERR_EN
        classic(0, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF);
`else
        classic(0, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 1'b0, 32'h0BADF00D);
`endif

        // reset pulse while a write waits out its wait states
        classic(2, 1'b1, 32'h80, 32'h5555AAAA, 4'hF, 1'b0, 32'h0);
        classic(2, 1'b0, 32'h80, 32'h0,        4'hF, 1'b0, 32'h5555AAAA);
        @(posedge clk); #1;
        m_adr[2] = 32'h80; m_dat[2] = 32'hDEADDEAD; m_sel[2] = 4'hF; m_we[2] = 1'b1;
        m_cti[2] = 3'b000; m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst[2] = 1'b1;
        @(negedge clk);
        chk("midrst_ack", {31'h0, s_ack[2]}, 32'h0);
        chk("midrst_dat", s_dat[2], 32'h0);
        @(posedge clk); #1;
        rst[2] = 1'b0; m_cyc[2] = 1'b0; m_stb[2] = 1'b0; m_we[2] = 1'b0;
        repeat (5) @(negedge clk);
        chk("postrst_dat", s_dat[2], 32'h0);
        classic(2, 1'b0, 32'h80, 32'h0, 4'hF, 1'b0, 32'h5555AAAA);

        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_resp: %0d expected responses never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
